// File: rtl/wd_reset_sequencer_if.sv
// Control/status bundle between the watchdog-driven reset sequencer and its surroundings.
// The sequencer uses the slave view; the watchdog/status side uses the master view.
interface wd_reset_sequencer_if #(
  parameter int unsigned GAIN_W = 8
);
  logic              force_reset;
  logic              warning;
  logic              clear_fault;
  logic [GAIN_W-1:0] gain_out;
  logic              rf_en;
  logic              sys_rstn;
  logic              fault_latched;
  logic [3:0]        trip_count;
  logic [2:0]        state_o;

  modport master (
    output force_reset, warning, clear_fault,
    input  gain_out, rf_en, sys_rstn, fault_latched, trip_count, state_o
  );

  modport slave (
    input  force_reset, warning, clear_fault,
    output gain_out, rf_en, sys_rstn, fault_latched, trip_count, state_o
  );
endinterface

// File: rtl/wd_reset_sequencer.sv
// Watchdog reset sequencer: ramps modulator gain down, holds the DSP reset, then ramps back up.
// Repeated trips latch a lockout that only clear_fault can release.
module wd_reset_sequencer #(
  parameter int unsigned GAIN_W      = 8,
  parameter int unsigned RAMP_STEP   = 16,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned MAX_TRIPS   = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  wd_reset_sequencer_if.slave    bus
);

  localparam int unsigned GW1    = GAIN_W + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [GAIN_W-1:0] GMAX    = '1;
  localparam logic [GAIN_W-1:0] GHALF   = GAIN_W'(2 ** (GAIN_W - 1));
  localparam logic [GW1-1:0]    GMAX_X  = {1'b0, GMAX};
  localparam logic [GW1-1:0]    GHALF_X = {1'b0, GHALF};
  localparam logic [GW1-1:0]    STEP_X  = GW1'(RAMP_STEP);
  localparam logic [3:0]        TRIP_LIM = 4'(MAX_TRIPS);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RAMP_UP    = 3'd0,
    S_RUN        = 3'd1,
    S_WARN       = 3'd2,
    S_RAMP_DOWN  = 3'd3,
    S_HOLD       = 3'd4,
    S_WAIT_CLEAR = 3'd5,
    S_LOCKOUT    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic                rf_en_q, rf_en_d;
  logic                sys_rstn_q, sys_rstn_d;
  logic                fault_q, fault_d;
  logic [3:0]          trip_q, trip_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [GW1-1:0]      gain_x;
  logic [GW1-1:0]      up_x;
  logic [GAIN_W-1:0]   gain_up;
  logic [GAIN_W-1:0]   gain_dn;
  logic [GAIN_W-1:0]   gain_wn;
  logic [3:0]          trip_inc;

  // Saturating gain arithmetic, one bit wider than the gain so nothing wraps.
  always_comb begin
    gain_x  = {1'b0, gain_q};
    up_x    = gain_x + STEP_X;
    gain_up = (up_x > GMAX_X) ? GMAX : GAIN_W'(up_x);
    gain_dn = (gain_x > STEP_X) ? GAIN_W'(gain_x - STEP_X) : '0;
    if (gain_x > GHALF_X) begin
      gain_wn = ((gain_x - GHALF_X) > STEP_X) ? GAIN_W'(gain_x - STEP_X) : GHALF;
    end else begin
      gain_wn = ((GHALF_X - gain_x) > STEP_X) ? GAIN_W'(gain_x + STEP_X) : GHALF;
    end
    trip_inc = (trip_q == 4'hF) ? 4'hF : trip_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_RAMP_UP;
      gain_q     <= '0;
      rf_en_q    <= 1'b1;
      sys_rstn_q <= 1'b1;
      fault_q    <= 1'b0;
      trip_q     <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      rf_en_q    <= rf_en_d;
      sys_rstn_q <= sys_rstn_d;
      fault_q    <= fault_d;
      trip_q     <= trip_d;
      hold_q     <= hold_d;
    end
  end

  // Next state: force_reset outranks warning in the audio-carrying states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RAMP_UP: begin
        if (bus.force_reset)      state_d = S_RAMP_DOWN;
        else if (bus.warning)     state_d = S_WARN;
        else if (gain_q == GMAX)  state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.force_reset)      state_d = S_RAMP_DOWN;
        else if (bus.warning)     state_d = S_WARN;
      end
      S_WARN: begin
        if (bus.force_reset)      state_d = S_RAMP_DOWN;
        else if (!bus.warning)    state_d = S_RAMP_UP;
      end
      S_RAMP_DOWN: begin
        if (gain_dn == '0)        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == '0)         state_d = (trip_q >= TRIP_LIM) ? S_LOCKOUT : S_WAIT_CLEAR;
      end
      S_WAIT_CLEAR: begin
        if (!bus.force_reset)     state_d = S_RAMP_UP;
      end
      S_LOCKOUT: begin
        if (bus.clear_fault)      state_d = S_RAMP_UP;
      end
      default:                    state_d = S_RAMP_DOWN;
    endcase
  end

  // Next values of the registered outputs; gain holds on the edge that leaves a state early.
  always_comb begin
    gain_d     = gain_q;
    rf_en_d    = rf_en_q;
    sys_rstn_d = sys_rstn_q;
    fault_d    = fault_q;
    trip_d     = bus.clear_fault ? 4'd0 : trip_q;
    hold_d     = hold_q;
    case (state_q)
      S_RAMP_UP: begin
        if (!bus.force_reset && !bus.warning) gain_d = gain_up;
      end
      S_RUN: begin
        gain_d = gain_q;
      end
      S_WARN: begin
        if (!bus.force_reset && bus.warning) gain_d = gain_wn;
      end
      S_RAMP_DOWN: begin
        gain_d = gain_dn;
        if (gain_dn == '0) begin
          rf_en_d    = 1'b0;
          sys_rstn_d = 1'b0;
          trip_d     = bus.clear_fault ? 4'd1 : trip_inc;
          hold_d     = HOLD_INIT;
        end
      end
      S_HOLD: begin
        gain_d  = '0;
        rf_en_d = 1'b0;
        if (hold_q == '0) begin
          sys_rstn_d = 1'b1;
          if (trip_q >= TRIP_LIM) fault_d = 1'b1;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_WAIT_CLEAR: begin
        gain_d  = '0;
        rf_en_d = !bus.force_reset;
      end
      S_LOCKOUT: begin
        gain_d     = '0;
        rf_en_d    = 1'b0;
        sys_rstn_d = 1'b1;
        fault_d    = 1'b1;
        if (bus.clear_fault) begin
          fault_d = 1'b0;
          rf_en_d = 1'b1;
        end
      end
      default: begin
        gain_d = gain_q;
      end
    endcase
  end

  assign bus.gain_out      = gain_q;
  assign bus.rf_en         = rf_en_q;
  assign bus.sys_rstn      = sys_rstn_q;
  assign bus.fault_latched = fault_q;
  assign bus.trip_count    = trip_q;
  assign bus.state_o       = state_q;

endmodule
